// File: rtl/dual_read_pair_fetcher.sv
// dual_read_pair_fetcher
// Walks a window of `count` addresses. Each step reads word k on RAM port A and
// word k+offset on port B in the same cycle, then returns the pairs on a
// valid/ready stream, with o_last marking the final pair of a command. A 2-entry
// output FIFO absorbs the RAM's one-cycle read latency and any back-pressure.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, base_addr, offset,   command strobe and its parameters
//   count
//   busy, done                  command status and completion pulse
//   ram_wr_busy                 RAM write strobe; reads are held off while high
//   rd_addr_a/b, rd_en_a/b      RAM read request (combinational issue decision)
//   rd_data_a/b                 RAM read data, valid one cycle after the enable
//   o_data_a/b, o_valid,        output pair stream
//   o_ready, o_last
module dual_read_pair_fetcher #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 64,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [AW-1:0]         base_addr,
   input  logic [AW-1:0]         offset,
   input  logic [AW:0]           count,
   output logic                  busy,
   output logic                  done,
   input  logic                  ram_wr_busy,
   output logic [AW-1:0]         rd_addr_a,
   output logic [AW-1:0]         rd_addr_b,
   output logic                  rd_en_a,
   output logic                  rd_en_b,
   input  logic [DATA_WIDTH-1:0] rd_data_a,
   input  logic [DATA_WIDTH-1:0] rd_data_b,
   output logic [DATA_WIDTH-1:0] o_data_a,
   output logic [DATA_WIDTH-1:0] o_data_b,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic                  o_last
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic                  last;
   } pair_t;

   state_t         state_q, state_d;
   logic [AW:0]    k_q;
   logic [AW:0]    count_q;
   logic [AW-1:0]  base_q;
   logic [AW-1:0]  offset_q;
   logic [AW-1:0]  addr_a_q, addr_b_q;
   logic [1:0]     occ_q;
   logic           inflight_q;
   logic           inflight_last_q;
   logic           wr_ptr_q, rd_ptr_q;
   logic           done_q;
   pair_t          fifo_q [2];

   logic           pop;
   logic           space_ok;
   logic [1:0]     occ_d;
   logic           issue;
   logic           accept;
   logic           done_d;
   logic           last_k;
   logic [AW-1:0]  addr_a_c, addr_b_c;

   // Stream handshake and FIFO accounting; a read issued last cycle is pushed now.
   assign pop      = (occ_q != 2'd0) & o_ready;
   assign occ_d    = occ_q + 2'(inflight_q) - 2'(pop);
   assign space_ok = (3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
   assign last_k   = (k_q + (AW+1)'(1)) == count_q;

   // Window addresses; sums wrap modulo DEPTH on purpose.
   assign addr_a_c = AW'(base_q + k_q[AW-1:0]);
   assign addr_b_c = AW'(base_q + k_q[AW-1:0] + offset_q);

   // Next-state, read issue and completion decision.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      accept  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = (count == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (k_q < count_q) issue = ~ram_wr_busy & space_ok;
            else               state_d = DRAIN;
         end
         DRAIN: begin
            // done is raised once the FIFO will be empty after this cycle
            if (done_q)                state_d = IDLE;
            else if (occ_d == 2'd0)    done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, command parameters, read pipeline and FIFO storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         k_q             <= '0;
         count_q         <= '0;
         base_q          <= '0;
         offset_q        <= '0;
         addr_a_q        <= '0;
         addr_b_q        <= '0;
         occ_q           <= 2'd0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         done_q          <= 1'b0;
         fifo_q[0]       <= '0;
         fifo_q[1]       <= '0;
      end else begin
         state_q         <= state_d;
         done_q          <= done_d;
         inflight_q      <= issue;
         inflight_last_q <= issue & last_k;
         occ_q           <= occ_d;
         if (accept) begin
            base_q   <= base_addr;
            offset_q <= offset;
            count_q  <= count;
            k_q      <= '0;
         end else if (issue) begin
            k_q <= k_q + (AW+1)'(1);
         end
         if (issue) begin
            addr_a_q <= addr_a_c;
            addr_b_q <= addr_b_c;
         end
         if (inflight_q) begin
            fifo_q[wr_ptr_q] <= '{a: rd_data_a, b: rd_data_b, last: inflight_last_q};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // Addresses hold their last issued value between reads.
   assign rd_en_a   = issue;
   assign rd_en_b   = issue;
   assign rd_addr_a = issue ? addr_a_c : addr_a_q;
   assign rd_addr_b = issue ? addr_b_c : addr_b_q;

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign o_valid   = (occ_q != 2'd0);
   assign o_data_a  = fifo_q[rd_ptr_q].a;
   assign o_data_b  = fifo_q[rd_ptr_q].b;
   assign o_last    = o_valid & fifo_q[rd_ptr_q].last;

endmodule

// File: tb/tb_dual_read_pair_fetcher.sv
// Directed bench for dual_read_pair_fetcher with a registered-read RAM model
// holding RAM[i] = i.
module tb_dual_read_pair_fetcher;

   localparam int unsigned DW = 16;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] offset = '0;
   logic [AW:0]   count = '0;
   logic          busy, done;
   logic          ram_wr_busy = 1'b0;
   logic [AW-1:0] rd_addr_a, rd_addr_b;
   logic          rd_en_a, rd_en_b;
   logic [DW-1:0] rd_data_a = '0, rd_data_b = '0;
   logic [DW-1:0] o_data_a, o_data_b;
   logic          o_valid;
   logic          o_ready = 1'b1;
   logic          o_last;

   logic [DW-1:0] ram [DEPTH];

   int n_checks = 0;
   int n_fail   = 0;

   int hs_a[$], hs_b[$], hs_last[$], hs_cyc[$];
   int ra[$], rb[$];
   int rd_en_cnt, rd_en_wb, first_rd, valid_cnt, first_valid;
   int done_cnt, done_cyc, busy_last, viol, stab;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en_a) rd_data_a <= ram[rd_addr_a];
      if (rd_en_b) rd_data_b <= ram[rd_addr_b];
   end

   dual_read_pair_fetcher #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .offset(offset), .count(count), .busy(busy), .done(done),
      .ram_wr_busy(ram_wr_busy), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_data_a(rd_data_a),
      .rd_data_b(rd_data_b), .o_data_a(o_data_a), .o_data_b(o_data_b),
      .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_zero_outputs(input string pfx);
      check_eq({pfx, "_busy"},  32'(busy), 0);
      check_eq({pfx, "_done"},  32'(done), 0);
      check_eq({pfx, "_rden"},  32'({rd_en_a, rd_en_b}), 0);
      check_eq({pfx, "_valid"}, 32'(o_valid), 0);
      check_eq({pfx, "_last"},  32'(o_last), 0);
      check_eq({pfx, "_addra"}, 32'(rd_addr_a), 0);
      check_eq({pfx, "_addrb"}, 32'(rd_addr_b), 0);
      check_eq({pfx, "_da"},    32'(o_data_a), 0);
      check_eq({pfx, "_db"},    32'(o_data_b), 0);
   endtask

   // Issues one command (start sampled at edge 0) and observes cycles 1..ncyc.
   // rdy_mode 0: o_ready=1; 1: o_ready high in cycles 1,4,7,...
   task automatic run_cmd(input int base, input int off, input int cnt, input int rdy_mode,
                          input int wb_lo, input int wb_hi, input int st_lo, input int st_hi,
                          input int rst_c, input int ncyc);
      int occ_m, en1, en2, pop1, pop, stall;
      logic [DW-1:0] pa, pb;
      logic pl;
      hs_a.delete(); hs_b.delete(); hs_last.delete(); hs_cyc.delete();
      ra.delete(); rb.delete();
      rd_en_cnt = 0; rd_en_wb = 0; first_rd = -1; valid_cnt = 0; first_valid = -1;
      done_cnt = 0; done_cyc = -1; busy_last = -1; viol = 0; stab = 0;
      occ_m = 0; en1 = 0; en2 = 0; pop1 = 0; stall = 0; pa = '0; pb = '0; pl = 1'b0;
      @(posedge clk); #1;
      base_addr = AW'(base); offset = AW'(off); count = (AW+1)'(cnt);
      start = 1'b1; o_ready = 1'b1; ram_wr_busy = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         o_ready     = (rdy_mode == 0) ? 1'b1 : ((c % 3) == 1);
         ram_wr_busy = (c >= wb_lo) && (c <= wb_hi);
         start       = (c >= st_lo) && (c <= st_hi);
         count       = start ? (AW+1)'(2) : (AW+1)'(cnt);
         @(negedge clk);
         occ_m = occ_m + en2 - pop1;
         pop   = int'(o_valid & o_ready);
         if (o_valid != (occ_m != 0)) viol++;
         if (rd_en_a != rd_en_b) viol++;
         if (rd_en_a && (occ_m + en1 - pop >= 2)) viol++;
         if (stall != 0 && (!o_valid || o_data_a != pa || o_data_b != pb || o_last != pl)) stab++;
         if (rd_en_a) begin
            rd_en_cnt++;
            if (ram_wr_busy) rd_en_wb++;
            if (first_rd < 0) first_rd = c;
            ra.push_back(int'(rd_addr_a));
            rb.push_back(int'(rd_addr_b));
         end
         if (o_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = c;
         end
         if (pop != 0) begin
            hs_a.push_back(int'(o_data_a));
            hs_b.push_back(int'(o_data_b));
            hs_last.push_back(int'(o_last));
            hs_cyc.push_back(c);
         end
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (busy) busy_last = c;
         en2 = en1; en1 = int'(rd_en_a); pop1 = pop;
         stall = int'(o_valid & ~o_ready);
         pa = o_data_a; pb = o_data_b; pl = o_last;
         if (c == rst_c) begin
            rst_n = 1'b0;
            #1;
            check_zero_outputs("rst_mid");
            rst_n = 1'b1;
            occ_m = 0; en1 = 0; en2 = 0; pop1 = 0; stall = 0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; ram_wr_busy = 1'b0; o_ready = 1'b1;
   endtask

   task automatic check_pairs(input string pfx, input int base, input int off, input int n);
      check_eq({pfx, "_npairs"}, 32'(hs_a.size()), 32'(n));
      for (int i = 0; i < n && i < hs_a.size(); i++) begin
         check_eq($sformatf("%s_a%0d", pfx, i), 32'(hs_a[i]), 32'((base + i) % 64));
         check_eq($sformatf("%s_b%0d", pfx, i), 32'(hs_b[i]), 32'((base + i + off) % 64));
         check_eq($sformatf("%s_last%0d", pfx, i), 32'(hs_last[i]), 32'(i == n - 1));
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = DW'(i);
      rst_n = 1'b0;
      #12;
      check_zero_outputs("rst");
      rst_n = 1'b1;

      // Basic: base 4, offset 8, count 4
      run_cmd(4, 8, 4, 0, 0, -1, 0, -1, 0, 10);
      check_pairs("t1", 4, 8, 4);
      for (int i = 0; i < 4 && i < hs_cyc.size(); i++)
         check_eq($sformatf("t1_cyc%0d", i), 32'(hs_cyc[i]), 32'(3 + i));
      check_eq("t1_first_rd", 32'(first_rd), 1);
      check_eq("t1_first_valid", 32'(first_valid), 3);
      check_eq("t1_rd_cnt", 32'(rd_en_cnt), 4);
      check_eq("t1_done_cnt", 32'(done_cnt), 1);
      check_eq("t1_done_cyc", 32'(done_cyc), 7);
      check_eq("t1_busy_last", 32'(busy_last), 7);
      check_eq("t1_viol", 32'(viol), 0);

      // Wrap-around: base 62, offset 3, count 3
      run_cmd(62, 3, 3, 0, 0, -1, 0, -1, 0, 8);
      check_eq("t2_naddr", 32'(ra.size()), 3);
      if (ra.size() == 3) begin
         check_eq("t2_ra0", 32'(ra[0]), 62);
         check_eq("t2_ra1", 32'(ra[1]), 63);
         check_eq("t2_ra2", 32'(ra[2]), 0);
         check_eq("t2_rb0", 32'(rb[0]), 1);
         check_eq("t2_rb1", 32'(rb[1]), 2);
         check_eq("t2_rb2", 32'(rb[2]), 3);
      end
      check_pairs("t2", 62, 3, 3);
      check_eq("t2_done_cyc", 32'(done_cyc), 6);

      // Back-pressure: count 6, o_ready 1,0,0,1,0,0,...
      run_cmd(10, 5, 6, 1, 0, -1, 0, -1, 0, 24);
      check_pairs("t3", 10, 5, 6);
      check_eq("t3_viol", 32'(viol), 0);
      check_eq("t3_stab", 32'(stab), 0);
      check_eq("t3_rd_cnt", 32'(rd_en_cnt), 6);
      check_eq("t3_done_cnt", 32'(done_cnt), 1);
      check_eq("t3_done_cyc", 32'(done_cyc), 20);

      // RAM write busy in cycles 2-4, count 5
      run_cmd(20, 1, 5, 0, 2, 4, 0, -1, 0, 14);
      check_pairs("t4", 20, 1, 5);
      check_eq("t4_rd_in_wb", 32'(rd_en_wb), 0);
      check_eq("t4_rd_cnt", 32'(rd_en_cnt), 5);
      check_eq("t4_done_cnt", 32'(done_cnt), 1);
      check_eq("t4_done_cyc", 32'(done_cyc), 11);
      check_eq("t4_viol", 32'(viol), 0);

      // count 0, with start re-asserted in cycles 1 and 2 (busy)
      run_cmd(0, 0, 0, 0, 0, -1, 1, 2, 0, 8);
      check_eq("t5_done_cyc", 32'(done_cyc), 2);
      check_eq("t5_done_cnt", 32'(done_cnt), 1);
      check_eq("t5_rd_cnt", 32'(rd_en_cnt), 0);
      check_eq("t5_valid_cnt", 32'(valid_cnt), 0);
      check_eq("t5_busy_last", 32'(busy_last), 2);

      // Reset during the third pair of count 8, then a fresh command
      run_cmd(0, 16, 8, 0, 0, -1, 0, -1, 5, 10);
      check_eq("t6_npairs", 32'(hs_a.size()), 3);
      check_eq("t6_done_cnt", 32'(done_cnt), 0);
      check_eq("t6_rd_cnt", 32'(rd_en_cnt), 5);
      run_cmd(40, 2, 2, 0, 0, -1, 0, -1, 0, 7);
      check_pairs("t6b", 40, 2, 2);
      check_eq("t6b_first_rd", 32'(first_rd), 1);
      check_eq("t6b_done_cyc", 32'(done_cyc), 5);
      check_eq("t6b_done_cnt", 32'(done_cnt), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
